// File: rtl/branch_pc_unit_pkg.sv
// branch_pc_unit_pkg: shared widths, FSM state encodings, reset/trap PC defaults and a sequential-PC helper.
package branch_pc_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam int CNT_W       = 3;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_PC_DEF  = 32'h0000_0100;

    function automatic logic [XLEN-1:0] next_seq(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/branch_target_gen.sv
// branch_target_gen: combinational taken decision, redirect target and misalignment detect.
//   in : Valid, Branch, BrNe, Jump, JumpR, BrRes, RD1, Imm, PC_EX
//   out: Taken, Target, Misaligned
module branch_target_gen
    import branch_pc_unit_pkg::*;
(
    input  logic            Valid,
    input  logic            Branch,
    input  logic            BrNe,
    input  logic            Jump,
    input  logic            JumpR,
    input  logic            BrRes,
    input  logic [XLEN-1:0] RD1,
    input  logic [XLEN-1:0] Imm,
    input  logic [XLEN-1:0] PC_EX,
    output logic            Taken,
    output logic [XLEN-1:0] Target,
    output logic            Misaligned
);

    always_comb begin
        Taken      = Valid & (Jump | JumpR | (Branch & (BrRes ^ BrNe)));
        // JALR clears bit 0 of the computed address; JumpR wins over Jump/Branch.
        Target     = JumpR ? ((RD1 + Imm) & ~XLEN'(1)) : (PC_EX + Imm);
        Misaligned = Target[1];
    end

endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: fetch PC / resolve-stage PC registers, branch redirect and multi-cycle flush FSM.
//   in : clk, rst (sync, active-high), Stall, Valid, Branch, BrNe, Jump, JumpR, BrRes, RD1, Imm
//   out: PC, PC_EX, LinkAddr (PC_EX + 4), Flush, Misalign (one-cycle pulse)
//   BRANCH_PC_UNIT_STATS_EN adds BrTakenCnt / BrNotTakenCnt conditional-branch counters.
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEF,
    parameter logic [XLEN-1:0] TRAP_PC      = TRAP_PC_DEF,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic            Valid,
    input  logic            Branch,
    input  logic            BrNe,
    input  logic            Jump,
    input  logic            JumpR,
    input  logic            BrRes,
    input  logic [XLEN-1:0] RD1,
    input  logic [XLEN-1:0] Imm,
`ifdef BRANCH_PC_UNIT_STATS_EN
    output logic [31:0]     BrTakenCnt,
    output logic [31:0]     BrNotTakenCnt,
`endif
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_EX,
    output logic [XLEN-1:0] LinkAddr,
    output logic            Flush,
    output logic            Misalign
);

    logic            taken;
    logic [XLEN-1:0] target;
    logic            misaligned;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_ex_q, pc_ex_d;
    logic [0:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            misalign_q, misalign_d;

    branch_target_gen u_tgt (
        .Valid      (Valid),
        .Branch     (Branch),
        .BrNe       (BrNe),
        .Jump       (Jump),
        .JumpR      (JumpR),
        .BrRes      (BrRes),
        .RD1        (RD1),
        .Imm        (Imm),
        .PC_EX      (pc_ex_q),
        .Taken      (taken),
        .Target     (target),
        .Misaligned (misaligned)
    );

    always_comb begin
        pc_d       = pc_q;
        pc_ex_d    = pc_ex_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        if (!Stall) begin
            pc_ex_d = pc_q;
            pc_d    = next_seq(pc_q);
            if (state_q == ST_RUN) begin
                if (taken) begin
                    pc_d       = misaligned ? TRAP_PC : target;
                    state_d    = ST_FLUSH;
                    cnt_d      = CNT_W'(FLUSH_CYCLES);
                    misalign_d = misaligned;
                end
            end else begin
                // Squashed slots: decision inputs are ignored, fetch runs sequentially.
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? ST_RUN : ST_FLUSH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pc_ex_q    <= RESET_PC;
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_ex_q    <= pc_ex_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef BRANCH_PC_UNIT_STATS_EN
    logic [31:0] bt_q, bt_d;
    logic [31:0] bnt_q, bnt_d;
    logic        count_en;
    logic        br_taken;

    always_comb begin
        count_en = (state_q == ST_RUN) & ~Stall & Valid & Branch;
        br_taken = BrRes ^ BrNe;
        bt_d     = (count_en &  br_taken) ? bt_q + 32'd1  : bt_q;
        bnt_d    = (count_en & ~br_taken) ? bnt_q + 32'd1 : bnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bt_q  <= '0;
            bnt_q <= '0;
        end else begin
            bt_q  <= bt_d;
            bnt_q <= bnt_d;
        end
    end

    assign BrTakenCnt    = bt_q;
    assign BrNotTakenCnt = bnt_q;
`endif

    assign PC       = pc_q;
    assign PC_EX    = pc_ex_q;
    assign LinkAddr = next_seq(pc_ex_q);
    assign Flush    = (state_q == ST_FLUSH);
    assign Misalign = misalign_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed self-checking bench for branch_pc_unit.
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        rst, Stall, Valid, Branch, BrNe, Jump, JumpR, BrRes;
    logic [31:0] RD1, Imm;
    logic [31:0] PC, PC_EX, LinkAddr;
    logic        Flush, Misalign;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_pc_unit dut (
        .clk      (clk),
        .rst      (rst),
        .Stall    (Stall),
        .Valid    (Valid),
        .Branch   (Branch),
        .BrNe     (BrNe),
        .Jump     (Jump),
        .JumpR    (JumpR),
        .BrRes    (BrRes),
        .RD1      (RD1),
        .Imm      (Imm),
        .PC       (PC),
        .PC_EX    (PC_EX),
        .LinkAddr (LinkAddr),
        .Flush    (Flush),
        .Misalign (Misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Valid = 0; Branch = 0; BrNe = 0; Jump = 0; JumpR = 0; BrRes = 0;
        RD1 = 0; Imm = 0; Stall = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        step();
        step();
        rst = 0;
        chk("rst_pc", PC, 32'h0);
        chk("rst_pcex", PC_EX, 32'h0);
        chk("rst_link", LinkAddr, 32'h4);
        chk("rst_flush", {31'b0, Flush}, 0);
        chk("rst_misalign", {31'b0, Misalign}, 0);

        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("seq_pc%0d", i), PC, 32'(i * 4));
            chk($sformatf("seq_flush%0d", i), {31'b0, Flush}, 0);
        end
        chk("seq_pcex", PC_EX, 32'h10);

        Stall = 1; Valid = 1; Jump = 1; Imm = 32'h40;
        step();
        chk("run_stall_pc", PC, 32'h14);
        chk("run_stall_flush", {31'b0, Flush}, 0);
        idle();

        Valid = 0; Jump = 1; Imm = 32'h40;
        step();
        chk("invalid_jump_pc", PC, 32'h18);
        chk("invalid_jump_flush", {31'b0, Flush}, 0);
        idle();
        chk("beq_pcex", PC_EX, 32'h14);

        Valid = 1; Branch = 1; BrNe = 0; BrRes = 1; Imm = 32'h20;
        step();
        idle();
        chk("beq_pc", PC, 32'h34);
        chk("beq_pcex_after", PC_EX, 32'h18);
        chk("beq_flush1", {31'b0, Flush}, 1);
        Valid = 1; Jump = 1; Imm = 32'h200;
        step();
        idle();
        chk("flush2_pc", PC, 32'h38);
        chk("flush2_flag", {31'b0, Flush}, 1);
        step();
        chk("flush_end_pc", PC, 32'h3C);
        chk("flush_end_flag", {31'b0, Flush}, 0);

        Valid = 1; Branch = 1; BrNe = 1; BrRes = 1; Imm = 32'h20;
        step();
        idle();
        chk("bne_nt_pc", PC, 32'h40);
        chk("bne_nt_flush", {31'b0, Flush}, 0);

        Valid = 1; Branch = 1; BrNe = 1; BrRes = 0; Imm = 32'hFFFF_FFF0;
        chk("bne_pcex", PC_EX, 32'h3C);
        step();
        idle();
        chk("bne_back_pc", PC, 32'h2C);
        chk("bne_back_flush", {31'b0, Flush}, 1);
        step();
        step();
        chk("bne_back_run", {31'b0, Flush}, 0);
        chk("bne_back_pc2", PC, 32'h34);

        Valid = 1; JumpR = 1; RD1 = 32'h1001; Imm = 32'h4;
        chk("jalr_link_pre", LinkAddr, 32'h34);
        step();
        idle();
        chk("jalr_pc", PC, 32'h1004);
        chk("jalr_flush", {31'b0, Flush}, 1);
        chk("jalr_misalign", {31'b0, Misalign}, 0);
        chk("jalr_link_post", LinkAddr, 32'h38);
        step();
        chk("jalr_pc2", PC, 32'h1008);
        chk("jalr_flush2", {31'b0, Flush}, 1);
        step();
        chk("jalr_pc3", PC, 32'h100C);
        chk("jalr_flush3", {31'b0, Flush}, 0);

        rst = 1;
        step();
        rst = 0;
        step();
        step();
        step();
        chk("mis_pcex", PC_EX, 32'h8);
        Valid = 1; Jump = 1; Imm = 32'h6;
        step();
        idle();
        chk("mis_pc", PC, 32'h100);
        chk("mis_pulse", {31'b0, Misalign}, 1);
        chk("mis_flush", {31'b0, Flush}, 1);
        step();
        chk("mis_pulse_end", {31'b0, Misalign}, 0);
        chk("mis_pc2", PC, 32'h104);
        step();
        chk("mis_flush_end", {31'b0, Flush}, 0);
        chk("stall_pcex", PC_EX, 32'h104);

        Valid = 1; Jump = 1; Imm = 32'h10;
        step();
        chk("jal_pc", PC, 32'h114);
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall_pc%0d", i), PC, 32'h114);
            chk($sformatf("stall_pcex%0d", i), PC_EX, 32'h108);
            chk($sformatf("stall_flush%0d", i), {31'b0, Flush}, 1);
        end
        Stall = 0;
        step();
        chk("unstall_pc", PC, 32'h118);
        chk("unstall_flush", {31'b0, Flush}, 1);
        rst = 1;
        step();
        rst = 0;
        idle();
        chk("midrst_pc", PC, 32'h0);
        chk("midrst_flush", {31'b0, Flush}, 0);
        step();
        chk("midrst_run_pc", PC, 32'h4);
        chk("midrst_run_flush", {31'b0, Flush}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
